// File: rtl/quadrilatero_lsu_arbiter_pkg.sv
// Shared types for the LSU arbiter slice: the LSU instruction and configuration
// records, the arbiter FSM states and the performance-counter width.
package quadrilatero_pkg;

    // Load/store instruction handed to the LSU
    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  vreg;
        logic [31:0] addr;
    } lsu_instr_t;

    // CSR configuration that travels with each instruction
    typedef struct packed {
        logic [31:0] stride;
        logic [7:0]  rows;
    } lsu_conf_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETTLE,
        ARB_RUN
    } lsu_arb_state_e;

    localparam int unsigned LSU_ARB_CNT_W = 32;

    // Saturating increment for the performance counters
    function automatic logic [LSU_ARB_CNT_W-1:0] sat_inc(input logic [LSU_ARB_CNT_W-1:0] v);
        return (&v) ? v : v + LSU_ARB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/quadrilatero_lsu_arbiter_if.sv
// Bus between the LSU issue queues, the LSU arbiter and the LSU.
// QUADRILATERO_LSU_ARB_PERF_EN adds the performance-counter outputs.
interface quadrilatero_lsu_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    import quadrilatero_pkg::*;

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]              req_i;
    lsu_instr_t [N_REQ-1:0]        instr_i;
    lsu_conf_t  [N_REQ-1:0]        conf_i;
    logic [N_REQ-1:0]              gnt_o;
    logic                          busy_o;
    logic                          start_o;
    lsu_instr_t                    instr_o;
    lsu_conf_t                     conf_o;
    logic [IDX_W-1:0]              owner_o;
    logic                          lsu_busy_i;
`ifdef QUADRILATERO_LSU_ARB_PERF_EN
    logic [LSU_ARB_CNT_W-1:0]       perf_busy_cycles_o;
    logic [N_REQ*LSU_ARB_CNT_W-1:0] perf_stall_cycles_o;

    modport slave (
        input  req_i, instr_i, conf_i, lsu_busy_i,
        output gnt_o, busy_o, start_o, instr_o, conf_o, owner_o,
               perf_busy_cycles_o, perf_stall_cycles_o
    );
    modport master (
        output req_i, instr_i, conf_i, lsu_busy_i,
        input  gnt_o, busy_o, start_o, instr_o, conf_o, owner_o,
               perf_busy_cycles_o, perf_stall_cycles_o
    );
`else
    modport slave (
        input  req_i, instr_i, conf_i, lsu_busy_i,
        output gnt_o, busy_o, start_o, instr_o, conf_o, owner_o
    );
    modport master (
        output req_i, instr_i, conf_i, lsu_busy_i,
        input  gnt_o, busy_o, start_o, instr_o, conf_o, owner_o
    );
`endif

endinterface

// File: rtl/quadrilatero_lsu_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module quadrilatero_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan from the pointer, wrapping, and take the first pending slot
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/quadrilatero_lsu_arbiter.sv
// Shares one LSU between N_REQ issue controllers. Grants one request at a time
// round-robin, pulses start_o, and holds the granted instruction/config until
// the LSU drops busy. QUADRILATERO_LSU_ARB_PERF_EN adds busy/stall counters.
module quadrilatero_lsu_arbiter
    import quadrilatero_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned SETTLE = 1
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    quadrilatero_lsu_arbiter_if.slave lsu_if
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    lsu_arb_state_e    state_q;
    logic [SCNT_W-1:0] cnt_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              start_q;
    lsu_instr_t        instr_q;
    lsu_conf_t         conf_q;

    logic [N_REQ-1:0]  win_gnt;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_nxt;
    logic              can_issue;

    quadrilatero_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) i_rr (
        .req_i (lsu_if.req_i),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    assign can_issue = (|lsu_if.req_i) & ~lsu_if.lsu_busy_i;
    assign ptr_nxt   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // Arbitration FSM: grant and start are one-cycle pulses; the granted payload
    // stays latched. busy_i is ignored while the LSU is still settling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            instr_q <= '0;
            conf_q  <= '0;
        end else begin
            gnt_q   <= '0;
            start_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (can_issue) begin
                        instr_q <= lsu_if.instr_i[win_idx];
                        conf_q  <= lsu_if.conf_i[win_idx];
                        owner_q <= win_idx;
                        gnt_q   <= win_gnt;
                        start_q <= 1'b1;
                        ptr_q   <= ptr_nxt;
                        cnt_q   <= SCNT_W'(SETTLE - 1);
                        state_q <= ARB_SETTLE;
                    end
                end
                ARB_SETTLE: begin
                    if (cnt_q == '0) state_q <= ARB_RUN;
                    else             cnt_q   <= cnt_q - SCNT_W'(1);
                end
                ARB_RUN: begin
                    if (!lsu_if.lsu_busy_i) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign lsu_if.gnt_o   = gnt_q;
    assign lsu_if.start_o = start_q;
    assign lsu_if.instr_o = instr_q;
    assign lsu_if.conf_o  = conf_q;
    assign lsu_if.owner_o = owner_q;
    // A busy LSU seen while idle also blocks requesters
    assign lsu_if.busy_o  = (state_q != ARB_IDLE) | lsu_if.lsu_busy_i;

`ifdef QUADRILATERO_LSU_ARB_PERF_EN
    logic [LSU_ARB_CNT_W-1:0]             perf_busy_q, perf_busy_d;
    logic [N_REQ-1:0][LSU_ARB_CNT_W-1:0]  perf_stall_q, perf_stall_d;

    // Next counter values: busy counts non-idle cycles, stall counts unserved requests
    always_comb begin
        perf_busy_d  = (state_q != ARB_IDLE) ? sat_inc(perf_busy_q) : perf_busy_q;
        perf_stall_d = perf_stall_q;
        for (int r = 0; r < N_REQ; r++) begin
            if (lsu_if.req_i[r] && !gnt_q[r]) perf_stall_d[r] = sat_inc(perf_stall_q[r]);
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign lsu_if.perf_busy_cycles_o  = perf_busy_q;
    assign lsu_if.perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_quadrilatero_lsu_arbiter.sv
// Scoreboard bench for quadrilatero_lsu_arbiter (N_REQ=3, SETTLE=2).
module tb_quadrilatero_lsu_arbiter;
    import quadrilatero_pkg::*;

    localparam int N  = 3;
    localparam int S  = 2;
    localparam int IW = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    quadrilatero_lsu_arbiter_if #(.N_REQ(N)) bus ();
    quadrilatero_lsu_arbiter #(.N_REQ(N), .SETTLE(S)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lsu_if (bus)
    );

    typedef struct { int r; int seq; int gap; } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_start = 0;
    int meas_busy = 0;
    int n_starts = 0;
    int tgt [N];
    int gcnt [N];
    int op_len = 0;
    int lsu_k = 0;
    bit lsu_act = 1'b0;
    logic [N-1:0] extra_req = '0;
    logic lsu_force = 1'b0;

    function automatic lsu_instr_t mk_instr(input int r, input int seq);
        lsu_instr_t v;
        v.opcode = 3'(r + 1);
        v.vreg   = 4'(seq + 3 * r);
        v.addr   = 32'h1000_0000 + 32'(r * 256 + seq * 4);
        return v;
    endfunction

    function automatic lsu_conf_t mk_conf(input int r, input int seq);
        lsu_conf_t v;
        v.stride = 32'(64 + r * 8 + seq);
        v.rows   = 8'(r * 16 + seq + 1);
        return v;
    endfunction

    // Requester queues and LSU model, driven #1 after each rising edge
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lsu_act = 1'b0;
            lsu_k = 0;
            for (int r = 0; r < N; r++) gcnt[r] = 0;
            bus.req_i      = '0;
            bus.instr_i    = '0;
            bus.conf_i     = '0;
            bus.lsu_busy_i = 1'b0;
        end else begin
            #1;
            if (bus.start_o === 1'b1) begin lsu_act = 1'b1; lsu_k = 0; end
            for (int r = 0; r < N; r++) if (bus.gnt_o[r] === 1'b1) gcnt[r]++;
            if (lsu_act) begin
                lsu_k++;
                if (lsu_k > S + op_len) lsu_act = 1'b0;
            end
            bus.lsu_busy_i = lsu_force | (lsu_act && lsu_k > S && lsu_k <= S + op_len);
            for (int r = 0; r < N; r++) begin
                bus.req_i[r]   = (tgt[r] > gcnt[r]) | extra_req[r];
                bus.instr_i[r] = mk_instr(r, gcnt[r]);
                bus.conf_i[r]  = mk_conf(r, gcnt[r]);
            end
        end
    end

    // Scoreboard: every start_o pops one expected grant
    always @(negedge clk_i) begin : mon
        exp_t e;
        logic [N-1:0] eg;
        cyc++;
        if (!rst_ni) meas_busy = 0;
        else begin
            if (bus.busy_o === 1'b1) meas_busy++;
            if (bus.start_o === 1'b1) begin
                n_starts++;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_start cyc=%0d gnt=%b owner=%0d required=no start", cyc, bus.gnt_o, bus.owner_o);
                end else begin
                    e = sbq.pop_front();
                    eg = '0;
                    eg[e.r] = 1'b1;
                    checks++;
                    if (bus.gnt_o !== eg) begin
                        failures++; $display("FAIL gnt cyc=%0d got=%b required=%b", cyc, bus.gnt_o, eg);
                    end
                    checks++;
                    if (bus.owner_o !== IW'(e.r)) begin
                        failures++; $display("FAIL owner cyc=%0d got=%0d required=%0d", cyc, bus.owner_o, e.r);
                    end
                    checks++;
                    if (bus.instr_o !== mk_instr(e.r, e.seq)) begin
                        failures++; $display("FAIL instr cyc=%0d got=%h required=%h", cyc, bus.instr_o, mk_instr(e.r, e.seq));
                    end
                    checks++;
                    if (bus.conf_o !== mk_conf(e.r, e.seq)) begin
                        failures++; $display("FAIL conf cyc=%0d got=%h required=%h", cyc, bus.conf_o, mk_conf(e.r, e.seq));
                    end
                    if (e.gap > 0) begin
                        checks++;
                        if (cyc - last_start != e.gap) begin
                            failures++; $display("FAIL start_gap cyc=%0d got=%0d required=%0d", cyc, cyc - last_start, e.gap);
                        end
                    end
                end
                last_start = cyc;
            end else if (bus.gnt_o !== '0) begin
                checks++;
                failures++;
                $display("FAIL gnt_without_start cyc=%0d got=%b required=0", cyc, bus.gnt_o);
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int r = 0; r < N; r++) tgt[r] = 0;
        extra_req = '0;
        lsu_force = 1'b0;
        op_len = 0;
        sbq.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while ((sbq.size() != 0 || bus.busy_o !== 1'b0) && n < budget) begin
            @(negedge clk_i); n++;
        end
        checks++;
        if (n >= budget) begin
            failures++; $display("FAIL %s_timeout pending=%0d busy=%b required=drained", nm, sbq.size(), bus.busy_o);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        int ns = 0;
        do_reset();
        checks++; if (bus.gnt_o !== '0)    begin failures++; $display("FAIL rst_gnt got=%b required=0", bus.gnt_o); end
        checks++; if (bus.start_o !== 1'b0) begin failures++; $display("FAIL rst_start got=%b required=0", bus.start_o); end
        checks++; if (bus.busy_o !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b required=0", bus.busy_o); end
        checks++; if (bus.owner_o !== '0)  begin failures++; $display("FAIL rst_owner got=%0d required=0", bus.owner_o); end
        checks++; if (bus.instr_o !== '0)  begin failures++; $display("FAIL rst_instr got=%h required=0", bus.instr_o); end
        checks++; if (bus.conf_o !== '0)   begin failures++; $display("FAIL rst_conf got=%h required=0", bus.conf_o); end
        op_len = 20; tgt[2] = 1;
        sbq.push_back('{2, 0, 0});
        while (!(bus.lsu_busy_i === 1'b1 && lsu_k == S + 3) && n < 60) begin @(negedge clk_i); n++; end
        checks++; if (n >= 60) begin failures++; $display("FAIL rst_reach_run_timeout got=%0d required=<60", n); end
        checks++; if (bus.owner_o !== IW'(2)) begin failures++; $display("FAIL run_owner got=%0d required=2", bus.owner_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL run_busy got=%b required=1", bus.busy_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.gnt_o !== '0)    begin failures++; $display("FAIL midrst_gnt got=%b required=0", bus.gnt_o); end
        checks++; if (bus.start_o !== 1'b0) begin failures++; $display("FAIL midrst_start got=%b required=0", bus.start_o); end
        checks++; if (bus.busy_o !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b required=0", bus.busy_o); end
        checks++; if (bus.owner_o !== '0)  begin failures++; $display("FAIL midrst_owner got=%0d required=0", bus.owner_o); end
        do_reset();
        repeat (10) begin @(negedge clk_i); if (bus.start_o === 1'b1) ns++; end
        checks++; if (ns != 0) begin failures++; $display("FAIL post_rst_starts got=%0d required=0", ns); end
    endtask

    task automatic test_single();
        int n = 0;
        int nb = 0;
        int ns = 0;
        do_reset();
        lsu_force = 1'b1; op_len = 5; tgt[1] = 2;
        sbq.push_back('{1, 0, 0});
        sbq.push_back('{1, 1, S + 5 + 2});
        repeat (4) begin
            @(negedge clk_i);
            if (bus.busy_o === 1'b1) nb++;
            if (bus.start_o === 1'b1) ns++;
        end
        checks++; if (nb != 4) begin failures++; $display("FAIL idle_lsu_busy_busy got=%0d required=4", nb); end
        checks++; if (ns != 0) begin failures++; $display("FAIL idle_lsu_busy_start got=%0d required=0", ns); end
        lsu_force = 1'b0;
        do begin @(negedge clk_i); n++; end while (bus.start_o !== 1'b1 && n < 20);
        checks++; if (n != 2) begin failures++; $display("FAIL grant_latency got=%0d required=2", n); end
        nb = (bus.busy_o === 1'b1) ? 1 : 0;
        ns = 0;
        repeat (S + 5) begin
            @(negedge clk_i);
            if (bus.busy_o === 1'b1) nb++;
            if (bus.start_o === 1'b1) ns++;
        end
        checks++; if (nb != S + 6) begin failures++; $display("FAIL op_busy got=%0d required=%0d", nb, S + 6); end
        checks++; if (ns != 0) begin failures++; $display("FAIL early_regrant got=%0d required=0", ns); end
        wait_done("single", 100);
    endtask

    task automatic test_round_robin();
        int s0;
        do_reset();
        s0 = n_starts;
        op_len = 3; tgt[0] = 2; tgt[1] = 1; tgt[2] = 1;
        sbq.push_back('{0, 0, 0});
        sbq.push_back('{1, 0, 1 + S + 3 + 1});
        sbq.push_back('{2, 0, 1 + S + 3 + 1});
        sbq.push_back('{0, 1, 1 + S + 3 + 1});
        wait_done("rr", 200);
        checks++; if (n_starts - s0 != 4) begin failures++; $display("FAIL rr_starts got=%0d required=4", n_starts - s0); end
    endtask

    task automatic test_collision();
        int n = 0;
        int s0;
        do_reset();
        s0 = n_starts;
        op_len = 4; tgt[0] = 1;
        sbq.push_back('{0, 0, 0});
        while (!(bus.lsu_busy_i === 1'b1 && lsu_k == S + op_len) && n < 40) begin @(negedge clk_i); n++; end
        checks++; if (n >= 40) begin failures++; $display("FAIL coll_reach_timeout got=%0d required=<40", n); end
        tgt[0] = 2; tgt[1] = 1;
        sbq.push_back('{1, 0, 1 + S + 4 + 1});
        sbq.push_back('{0, 1, 1 + S + 4 + 1});
        wait_done("coll", 200);
        checks++; if (n_starts - s0 != 3) begin failures++; $display("FAIL coll_starts got=%0d required=3", n_starts - s0); end
    endtask

    task automatic test_zero_len();
        int n = 0;
        int nb = 0;
        do_reset();
        op_len = 0; tgt[2] = 2;
        sbq.push_back('{2, 0, 0});
        sbq.push_back('{2, 1, 2 + S});
        while (bus.start_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL zl_start_timeout got=%0d required=<20", n); end
        while (bus.busy_o === 1'b1 && nb < 20) begin nb++; @(negedge clk_i); end
        checks++; if (nb != S + 1) begin failures++; $display("FAIL zl_nonidle got=%0d required=%0d", nb, S + 1); end
        wait_done("zl", 100);
    endtask

`ifdef QUADRILATERO_LSU_ARB_PERF_EN
    task automatic test_perf();
        int n = 0;
        do_reset();
        checks++; if (bus.perf_busy_cycles_o !== '0) begin failures++; $display("FAIL perf_busy_rst got=%0d required=0", bus.perf_busy_cycles_o); end
        checks++; if (bus.perf_stall_cycles_o !== '0) begin failures++; $display("FAIL perf_stall_rst got=%h required=0", bus.perf_stall_cycles_o); end
        op_len = 12; tgt[0] = 1;
        sbq.push_back('{0, 0, 0});
        while (bus.start_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL perf_start_timeout got=%0d required=<20", n); end
        extra_req = 3'b010;
        repeat (7) @(negedge clk_i);
        extra_req = '0;
        wait_done("perf", 100);
        checks++;
        if (bus.perf_stall_cycles_o[32 +: 32] !== 32'd7) begin
            failures++; $display("FAIL perf_stall1 got=%0d required=7", bus.perf_stall_cycles_o[32 +: 32]);
        end
        checks++;
        if (bus.perf_busy_cycles_o !== 32'(meas_busy)) begin
            failures++; $display("FAIL perf_busy got=%0d required=%0d", bus.perf_busy_cycles_o, meas_busy);
        end
        checks++;
        if (bus.perf_busy_cycles_o !== 32'(S + 12 + 1)) begin
            failures++; $display("FAIL perf_busy_abs got=%0d required=%0d", bus.perf_busy_cycles_o, S + 13);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_collision();
        test_zero_len();
`ifdef QUADRILATERO_LSU_ARB_PERF_EN
        test_perf();
`endif
        checks++;
        if (sbq.size() != 0) begin failures++; $display("FAIL leftover_expected got=%0d required=0", sbq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
